d_latch_unit: RTL and testbench
===============================

Name: d_latch_unit

Overview:
- Level-sensitive, gated D latch bank, WIDTH bits wide. Transparent while clk is high; holds its value while clk is low.
- Primary output is the inverted state q_bar. A true output q is available as an optional feature.
- Used as a storage and timing primitive inside the MAC datapath, for example as the half-cycle retiming stage of a master/slave pair.

Parameters:
- WIDTH, 1, number of independent latch bits.
- RESET_Q, 0, value of q (per bit, replicated) forced by reset; q_bar resets to ~RESET_Q.

Ports:
- clk  input  1  latch enable. High = transparent, low = hold.
- rst_n  input  1  synchronous, active-low reset, qualified by clk high.
- d  input  WIDTH  data input.
- q_bar  output  WIDTH  inverted latch state.
- q  output  WIDTH  true latch state. Present only with D_LATCH_Q_OUT_EN.

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n).
- Positional declaration order is fixed for drop-in compatibility: q_bar, d, clk, rst_n, then q (if enabled).
- Transparent phase (clk=1, rst_n=1): q_bar = ~d combinationally, bit by bit. Zero cycles of latency; only gate delay applies.
- Hold phase (clk=0): q_bar keeps the value present at the falling edge of clk. Changes on d and rst_n are ignored.
- Reset is synchronous to the enable level. When clk=1 and rst_n=0, q_bar = ~RESET_Q regardless of d. When clk=0, rst_n has no effect.
- Reset released while clk=1: the latch becomes transparent immediately and q_bar follows ~d.
- Reset asserted mid-hold: no effect until clk rises.
- d changing at the same instant clk falls: the pre-edge d is captured. The bench must not depend on this race; keep d stable for 1 time unit around the falling edge.
- Power-up before the first clk high: q_bar is X. There is no implicit initial value.
- Bits are fully independent; there is no cross-bit logic.
- Implementation is a gated SR-latch structure per bit: NAND gating of d/~d by clk, then a cross-coupled NAND pair. Reset forces the gated S/R inputs.
- No flip-flops and no edge-triggered constructs are allowed in the storage path.
- The design must be synthesisable as a latch; the latch inference is intentional.

Optional Feature:
- D_LATCH_Q_OUT_EN defined: port q is present and always equals ~q_bar, including during reset (q = RESET_Q) and hold.
- Undefined: port q is absent and only q_bar is driven. Cell count is unchanged, because the cross-coupled pair exists anyway.

Decomposition:
- Package d_latch_pkg holds:
  - the default WIDTH;
  - the RESET_Q default;
  - a localparam for the gate delay used in simulation (unit delay 0 by default).
- Sub-module d_latch_bit: a single-bit gated NAND latch with ports q_bar, q, d, clk, rst_n.
- d_latch_unit instantiates WIDTH copies of d_latch_bit in a generate loop and conditionally exposes q.

Test Plan:
- Transparency, WIDTH=1, rst_n=1, clk=1 from t=0. Drive d=0, then 1 at t=2, 0 at t=3, 1 at t=4. Required: q_bar = 1, 0, 1, 0 at those instants (plus gate delay).
- Hold: clk falls at t=5 with d=1, so q_bar=0. Toggle d 1/0/1/1 at t=6, 7, 8, 9. Required: q_bar stays 0 throughout the low phase.
- Reopen: clk rises at t=10 with d=1, so q_bar=0. d=0 at t=11, so q_bar=1 before clk falls at t=15.
- Reset: clk=1, d=1, rst_n=0. Required: q_bar=1 (RESET_Q=0), and q=0 if enabled.
  - Lower clk, then raise rst_n: q_bar stays 1.
  - Raise clk: q_bar = ~d = 0.
- Reset ignored in hold: clk=0 holding q_bar=0, pulse rst_n low for 2 units. Required: q_bar remains 0.
- Width and feature: WIDTH=8 with D_LATCH_Q_OUT_EN. Drive d=8'hA5 with clk high, then lower clk and drive d=8'h3C. Required: q=8'hA5 and q_bar=8'h5A, held until clk rises.

Source files
------------

// File: rtl/d_latch_pkg.sv
// Shared constants and gate helpers for the d_latch_unit bank.
// Feature macro: D_LATCH_Q_OUT_EN exposes the true output q.
package d_latch_pkg;

    // Default number of latch bits in a bank.
    localparam int DEF_WIDTH = 1;

    // Default value of q forced while reset is qualified by clk high.
    localparam logic DEF_RESET_Q = 1'b0;

    // Unit gate delay used by simulation models around the latch.
    localparam int GATE_DLY = 0;

    // Two-input NAND, the only gate type in the latch cell.
    function automatic logic nand2(input logic a, input logic b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/d_latch_unit_if.sv
// Data bundle for a d_latch_unit bank: data in, latch state out.
// Feature macro: D_LATCH_Q_OUT_EN adds the true output q.
interface d_latch_unit_if
    import d_latch_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q_bar;
`ifdef D_LATCH_Q_OUT_EN
    logic [WIDTH-1:0] q;
`endif

`ifdef D_LATCH_Q_OUT_EN
    modport master (
        output d,
        input  q_bar,
        input  q
    );

    modport slave (
        input  d,
        output q_bar,
        output q
    );
`else
    modport master (
        output d,
        input  q_bar
    );

    modport slave (
        input  d,
        output q_bar
    );
`endif

endinterface

// File: rtl/d_latch_bit.sv
// Single-bit gated D latch: NAND-gated S/R feeding a cross-coupled pair.
// Transparent while clk is high, holds while clk is low.
module d_latch_bit
    import d_latch_pkg::*;
#(
    parameter logic RESET_Q = DEF_RESET_Q
) (
    output logic q_bar,
    output logic q,
    input  logic d,
    input  logic clk,
    input  logic rst_n
);

    logic d_eff;
    logic s_n;
    logic r_n;
    logic state_d;
    logic state_q;

    // Gate d and ~d by the enable; reset steers the gated inputs.
    always_comb begin
        d_eff   = rst_n ? d : RESET_Q;
        s_n     = nand2(d_eff, clk);
        r_n     = nand2(~d_eff, clk);
        state_d = ~s_n;
    end

    // Cross-coupled pair: an active gated input sets the state.
    always_latch begin
        if (!(s_n && r_n)) begin
            state_q <= state_d;
        end
    end

    assign q     = state_q;
    assign q_bar = ~state_q;

endmodule

// File: rtl/d_latch_unit.sv
// WIDTH-bit bank of independent gated D latches, enable = clk level.
// Feature macro: D_LATCH_Q_OUT_EN adds port q (always ~q_bar).
module d_latch_unit
    import d_latch_pkg::*;
#(
    parameter int   WIDTH   = DEF_WIDTH,
    parameter logic RESET_Q = DEF_RESET_Q
) (
    output logic [WIDTH-1:0] q_bar,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst_n
`ifdef D_LATCH_Q_OUT_EN
    ,
    output logic [WIDTH-1:0] q
`endif
);

    logic [WIDTH-1:0] q_int;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_latch_bit #(
            .RESET_Q (RESET_Q)
        ) u_bit (
            .q_bar (q_bar[i]),
            .q     (q_int[i]),
            .d     (d[i]),
            .clk   (clk),
            .rst_n (rst_n)
        );
    end

`ifdef D_LATCH_Q_OUT_EN
    assign q = q_int;
`else
    logic [WIDTH-1:0] q_int_unused;
    assign q_int_unused = q_int;
`endif

endmodule

// File: tb/tb_d_latch_unit.sv
// Self-checking bench for d_latch_unit (8-bit bank, RESET_Q = 0).
// Directed latch scenarios followed by random clk/d/rst_n activity.
module tb_d_latch_unit;
    import d_latch_pkg::*;

    localparam int   W  = 8;
    localparam logic RQ = 1'b0;

    logic clk;
    logic rst_n;

    d_latch_unit_if #(.WIDTH(W)) lif ();

    int checks   = 0;
    int failures = 0;

    // Reference: value of q the latch should be holding/passing.
    logic [W-1:0] mdl_q;

    d_latch_unit #(
        .WIDTH   (W),
        .RESET_Q (RQ)
    ) dut (
        .q_bar (lif.q_bar),
        .d     (lif.d),
        .clk   (clk),
        .rst_n (rst_n)
`ifdef D_LATCH_Q_OUT_EN
        ,
        .q     (lif.q)
`endif
    );

    task automatic chk(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Latch rule: while enabled, q follows d (or the reset value);
    // while disabled, q keeps whatever it last followed.
    task automatic upd_model();
        if (clk) begin
            mdl_q = rst_n ? lif.d : {W{RQ}};
        end
    endtask

    // Settle, then compare against a fixed expected q_bar.
    task automatic step(input string tag, input logic [W-1:0] exp_qb);
        #(GATE_DLY + 1);
        upd_model();
        chk(tag, lif.q_bar, exp_qb);
`ifdef D_LATCH_Q_OUT_EN
        chk({tag, "_q"}, lif.q, ~exp_qb);
`endif
    endtask

    // Settle, then compare against the behavioural model.
    task automatic rstep(input int n);
        #(GATE_DLY + 1);
        upd_model();
        chk($sformatf("rnd%0d", n), lif.q_bar, ~mdl_q);
`ifdef D_LATCH_Q_OUT_EN
        chk($sformatf("rnd%0d_q", n), lif.q, mdl_q);
`endif
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b1;
        lif.d = '0;
        mdl_q = '0;
        #1;

        // reset state with enable high
        clk   = 1'b1;
        rst_n = 1'b0;
        lif.d = 8'hFF;
        step("rst_state", 8'hFF);

        // transparency
        rst_n = 1'b1;
        lif.d = 8'h00;
        step("tr_d0", 8'hFF);
        lif.d = 8'hFF;
        step("tr_d1", 8'h00);
        lif.d = 8'h00;
        step("tr_d0b", 8'hFF);
        lif.d = 8'hFF;
        step("tr_d1b", 8'h00);

        // hold: d toggles while clk low
        clk = 1'b0;
        step("fall", 8'h00);
        lif.d = 8'hFF;
        step("hold_a", 8'h00);
        lif.d = 8'h00;
        step("hold_b", 8'h00);
        lif.d = 8'hFF;
        step("hold_c", 8'h00);
        lif.d = 8'hFF;
        step("hold_d", 8'h00);

        // reopen
        clk = 1'b1;
        step("reopen", 8'h00);
        lif.d = 8'h00;
        step("reopen_d0", 8'hFF);
        clk = 1'b0;
        step("fall2", 8'hFF);

        // reset qualified by clk high, release in hold
        lif.d = 8'hFF;
        step("pre_open", 8'hFF);
        clk = 1'b1;
        step("open_d1", 8'h00);
        rst_n = 1'b0;
        step("rst_hi", 8'hFF);
        clk = 1'b0;
        step("rst_lo", 8'hFF);
        rst_n = 1'b1;
        step("rel_lo", 8'hFF);
        clk = 1'b1;
        step("rel_hi", 8'h00);

        // reset pulse ignored in hold
        clk = 1'b0;
        step("hold0", 8'h00);
        rst_n = 1'b0;
        step("rst_hold1", 8'h00);
        step("rst_hold2", 8'h00);
        rst_n = 1'b1;
        step("rst_hold_rel", 8'h00);

        // multi-bit pattern
        clk   = 1'b1;
        lif.d = 8'hA5;
        step("w_open", 8'h5A);
        clk = 1'b0;
        step("w_fall", 8'h5A);
        lif.d = 8'h3C;
        step("w_hold", 8'h5A);
        step("w_hold2", 8'h5A);
        clk = 1'b1;
        step("w_reopen", 8'hC3);

        // random activity: one input change per step, so d never
        // moves at the same instant as a clk edge
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 2))
                0: clk = ~clk;
                1: lif.d = W'($urandom);
                default: rst_n = ($urandom_range(0, 3) != 0);
            endcase
            rstep(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
